// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the video PLL out of reset, waits for a stable lock, then releases
// the downstream reset. A timeout or a lock loss re-resets the PLL; repeated
// failed attempts park the block in a sticky FAULT until clear_fault.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int RETRY_LIMIT         = 7
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        clear_fault,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic        sys_ready,
    output logic        fault,
    output logic [2:0]  retry_count,
    output logic [15:0] lock_loss_count
);

    localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [RST_W-1:0]  RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STABLE_DONE = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TIMEOUT_HIT = TO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [2:0]        RETRY_MAX   = 3'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t            state;
    logic              lock_meta;
    logic              lk;
    logic [RST_W-1:0]  rst_cnt;
    logic [STAB_W-1:0] stable_cnt;
    logic [TO_W-1:0]   timeout_cnt;
    logic [2:0]        retry_inc;

    assign retry_inc = retry_count + 3'd1;

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let lk take the old lock_meta, giving two real flop stages.
            lock_meta <= pll_locked;
            lk        <= lock_meta;
        end
    end

    // Supervisor FSM; outputs are registered alongside each state transition.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RESET_PLL;
            rst_cnt         <= '0;
            stable_cnt      <= '0;
            timeout_cnt     <= '0;
            retry_count     <= 3'd0;
            lock_loss_count <= 16'd0;
            pll_rst         <= 1'b1;
            sys_rst_n       <= 1'b0;
            sys_ready       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            unique case (state)
                S_RESET_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        state       <= S_WAIT_LOCK;
                        pll_rst     <= 1'b0;
                        timeout_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end

                // Both lock-acquisition states share one timeout budget so a
                // flapping lock cannot restart the clock on every bounce.
                S_WAIT_LOCK, S_STABILIZE: begin
                    if (state == S_STABILIZE && lk && stable_cnt == STABLE_DONE) begin
                        state       <= S_RUN;
                        retry_count <= 3'd0;
                        sys_rst_n   <= 1'b1;
                        sys_ready   <= 1'b1;
                    end else if (timeout_cnt == TIMEOUT_HIT) begin
                        retry_count <= retry_inc;
                        pll_rst     <= 1'b1;
                        rst_cnt     <= '0;
                        if (retry_inc == RETRY_MAX) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_RESET_PLL;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                        if (state == S_WAIT_LOCK) begin
                            if (lk) begin
                                state      <= S_STABILIZE;
                                stable_cnt <= '0;
                            end
                        end else if (lk) begin
                            stable_cnt <= stable_cnt + STAB_W'(1);
                        end else begin
                            state <= S_WAIT_LOCK;
                        end
                    end
                end

                S_RUN: begin
                    if (!lk) begin
                        state     <= S_RESET_PLL;
                        rst_cnt   <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst_n <= 1'b0;
                        sys_ready <= 1'b0;
                        if (lock_loss_count != 16'hFFFF) begin
                            lock_loss_count <= lock_loss_count + 16'd1;
                        end
                    end
                end

                S_FAULT: begin
                    if (clear_fault) begin
                        state       <= S_RESET_PLL;
                        rst_cnt     <= '0;
                        retry_count <= 3'd0;
                        fault       <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_RESET_PLL;
                    rst_cnt   <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    sys_ready <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
